// File: rtl/tlb_op_sequencer_pkg.sv
// Shared CP0/TLB types for the TLB instruction sequencer.
package tlb_op_sequencer_pkg;

  typedef enum logic [1:0] {
    TlbP  = 2'd0,
    TlbR  = 2'd1,
    TlbWi = 2'd2,
    TlbWr = 2'd3
  } tlb_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StIssue,
    StResp,
    StFlush,
    StDone
  } tlbseq_state_t;

endpackage

// File: rtl/tlb_op_sequencer.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR between the pipeline, the TLB array and CP0,
// one op in flight, with a flush/refetch after any mapping-affecting op.
module tlb_op_sequencer
  import tlb_op_sequencer_pkg::*;
#(
  parameter int unsigned IdxW = 3,
  parameter int unsigned PcW  = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  input  logic [1:0]      req_op_i,
  input  logic [PcW-1:0]  req_pc_i,
  output logic            req_ready_o,
  input  logic            kill_i,
  input  logic            cp0_busy_i,
  input  logic [IdxW-1:0] cp0_index_i,
  input  logic [IdxW-1:0] cp0_random_i,
  output logic            tlb_probe_o,
  output logic            tlb_rd_o,
  output logic            tlb_we_o,
  output logic [IdxW-1:0] tlb_idx_o,
  input  logic            tlb_resp_valid_i,
  input  logic            tlb_hit_i,
  input  logic [IdxW-1:0] tlb_hit_idx_i,
  output logic            cp0_tlbp_o,
  output logic            cp0_tlbr_o,
  output logic            probe_p_o,
  output logic [IdxW-1:0] probe_index_o,
  output logic            stall_o,
  output logic            flush_o,
  output logic [PcW-1:0]  refetch_pc_o,
  output logic            done_o
);

  tlbseq_state_t   state_q, state_d;
  tlb_op_t         op_q, op_d;
  logic [PcW-1:0]  pc_q, pc_d;
  logic [IdxW-1:0] idx_q, idx_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      op_q    <= TlbP;
      pc_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    pc_d          = pc_q;
    idx_d         = idx_q;
    req_ready_o   = 1'b0;
    tlb_probe_o   = 1'b0;
    tlb_rd_o      = 1'b0;
    tlb_we_o      = 1'b0;
    tlb_idx_o     = '0;
    cp0_tlbp_o    = 1'b0;
    cp0_tlbr_o    = 1'b0;
    probe_p_o     = 1'b0;
    probe_index_o = '0;
    stall_o       = 1'b0;
    flush_o       = 1'b0;
    refetch_pc_o  = '0;
    done_o        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Held low while reset is asserted so every output reads 0.
        req_ready_o = ~rst_i;
        if (req_valid_i && !kill_i) begin
          op_d    = tlb_op_t'(req_op_i);
          pc_d    = req_pc_i;
          state_d = cp0_busy_i ? StWait : StIssue;
        end
      end
      StWait: begin
        stall_o = 1'b1;
        if (kill_i) begin
          state_d = StIdle;
        end else if (!cp0_busy_i) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        stall_o   = 1'b1;
        idx_d     = cp0_index_i;
        tlb_idx_o = (op_q == TlbWr) ? cp0_random_i : cp0_index_i;
        unique case (op_q)
          TlbP:        tlb_probe_o = 1'b1;
          TlbR:        tlb_rd_o    = 1'b1;
          TlbWi, TlbWr: tlb_we_o   = 1'b1;
          default:     ;
        endcase
        state_d = (op_q == TlbP || op_q == TlbR) ? StResp : StFlush;
      end
      StResp: begin
        stall_o = 1'b1;
        if (tlb_resp_valid_i) begin
          if (op_q == TlbP) begin
            cp0_tlbp_o    = 1'b1;
            probe_p_o     = ~tlb_hit_i;
            probe_index_o = tlb_hit_i ? tlb_hit_idx_i : idx_q;
            state_d       = StDone;
          end else begin
            // TLBR may change the ASID, so younger fetches must be redone.
            cp0_tlbr_o = 1'b1;
            state_d    = StFlush;
          end
        end
      end
      StFlush: begin
        stall_o      = 1'b1;
        flush_o      = 1'b1;
        refetch_pc_o = pc_q + PcW'(4);
        state_d      = StDone;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Directed self-checking bench for tlb_op_sequencer.
module tb_tlb_op_sequencer;

  localparam int unsigned IdxW = 3;
  localparam int unsigned PcW  = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            req_valid_i;
  logic [1:0]      req_op_i;
  logic [PcW-1:0]  req_pc_i;
  logic            req_ready_o;
  logic            kill_i;
  logic            cp0_busy_i;
  logic [IdxW-1:0] cp0_index_i;
  logic [IdxW-1:0] cp0_random_i;
  logic            tlb_probe_o;
  logic            tlb_rd_o;
  logic            tlb_we_o;
  logic [IdxW-1:0] tlb_idx_o;
  logic            tlb_resp_valid_i;
  logic            tlb_hit_i;
  logic [IdxW-1:0] tlb_hit_idx_i;
  logic            cp0_tlbp_o;
  logic            cp0_tlbr_o;
  logic            probe_p_o;
  logic [IdxW-1:0] probe_index_o;
  logic            stall_o;
  logic            flush_o;
  logic [PcW-1:0]  refetch_pc_o;
  logic            done_o;

  int checks = 0;
  int errors = 0;

  // {ready, probe, rd, we, tlbp, tlbr, P, stall, flush, done}
  logic [9:0] ctl;
  assign ctl = {req_ready_o, tlb_probe_o, tlb_rd_o, tlb_we_o, cp0_tlbp_o, cp0_tlbr_o,
                probe_p_o, stall_o, flush_o, done_o};

  always #5 clk_i = ~clk_i;

  tlb_op_sequencer #(
    .IdxW(IdxW),
    .PcW (PcW)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_op_i        (req_op_i),
    .req_pc_i        (req_pc_i),
    .req_ready_o     (req_ready_o),
    .kill_i          (kill_i),
    .cp0_busy_i      (cp0_busy_i),
    .cp0_index_i     (cp0_index_i),
    .cp0_random_i    (cp0_random_i),
    .tlb_probe_o     (tlb_probe_o),
    .tlb_rd_o        (tlb_rd_o),
    .tlb_we_o        (tlb_we_o),
    .tlb_idx_o       (tlb_idx_o),
    .tlb_resp_valid_i(tlb_resp_valid_i),
    .tlb_hit_i       (tlb_hit_i),
    .tlb_hit_idx_i   (tlb_hit_idx_i),
    .cp0_tlbp_o      (cp0_tlbp_o),
    .cp0_tlbr_o      (cp0_tlbr_o),
    .probe_p_o       (probe_p_o),
    .probe_index_o   (probe_index_o),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .refetch_pc_o    (refetch_pc_o),
    .done_o          (done_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_valid_i = 1'b0; req_op_i = 2'd0; req_pc_i = '0; kill_i = 1'b0;
    cp0_busy_i = 1'b0; cp0_index_i = '0; cp0_random_i = '0; tlb_resp_valid_i = 1'b0;
    tlb_hit_i = 1'b0; tlb_hit_idx_i = '0;
    #1;
    checks++; if (ctl !== 10'b0 || tlb_idx_o !== '0 || probe_index_o !== '0 || refetch_pc_o !== '0)
      begin errors++; $display("FAIL reset_outputs: got ctl=%b pc=%h exp all zero", ctl, refetch_pc_o); end
    tick(); tick();
    rst_i = 1'b0;
    #1;
    checks++; if (ctl !== 10'b1000000000)
      begin errors++; $display("FAIL reset_idle: got ctl=%b exp 1000000000", ctl); end
  endtask

  task automatic test_tlbp_hit();
    req_valid_i = 1'b1; req_op_i = 2'd0; req_pc_i = 32'h0000_2000; cp0_index_i = 3'd2;
    #1;
    checks++; if (ctl !== 10'b1000000000)
      begin errors++; $display("FAIL hit_t0: got ctl=%b exp 1000000000", ctl); end
    tick(); req_valid_i = 1'b0; #1;
    checks++; if (ctl !== 10'b0100000100 || tlb_idx_o !== 3'd2)
      begin errors++; $display("FAIL hit_t1_probe: got ctl=%b idx=%0d exp 0100000100 idx=2", ctl, tlb_idx_o); end
    tick(); tlb_resp_valid_i = 1'b1; tlb_hit_i = 1'b1; tlb_hit_idx_i = 3'd5; #1;
    checks++; if (ctl !== 10'b0000100100 || probe_index_o !== 3'd5)
      begin errors++; $display("FAIL hit_t2_tlbp: got ctl=%b pidx=%0d exp 0000100100 pidx=5", ctl, probe_index_o); end
    tick(); tlb_resp_valid_i = 1'b0; tlb_hit_i = 1'b0; #1;
    checks++; if (ctl !== 10'b0000000001)
      begin errors++; $display("FAIL hit_t3_done: got ctl=%b exp 0000000001", ctl); end
    tick();
    checks++; if (ctl !== 10'b1000000000)
      begin errors++; $display("FAIL hit_t4_idle: got ctl=%b exp 1000000000", ctl); end
  endtask

  task automatic test_tlbp_miss();
    req_valid_i = 1'b1; req_op_i = 2'd0; cp0_index_i = 3'd6; tlb_hit_idx_i = 3'd3;
    tick(); req_valid_i = 1'b0; #1;
    checks++; if (ctl !== 10'b0100000100 || tlb_idx_o !== 3'd6)
      begin errors++; $display("FAIL miss_probe: got ctl=%b idx=%0d exp 0100000100 idx=6", ctl, tlb_idx_o); end
    // Index moves after issue; the miss must report the value seen at issue.
    tick(); cp0_index_i = 3'd1; tlb_resp_valid_i = 1'b1; tlb_hit_i = 1'b0; #1;
    checks++; if (ctl !== 10'b0000101100 || probe_index_o !== 3'd6)
      begin errors++; $display("FAIL miss_resp: got ctl=%b pidx=%0d exp 0000101100 pidx=6", ctl, probe_index_o); end
    tick(); tlb_resp_valid_i = 1'b0; #1;
    checks++; if (ctl !== 10'b0000000001)
      begin errors++; $display("FAIL miss_done: got ctl=%b exp 0000000001", ctl); end
    tick();
  endtask

  task automatic test_tlbwr();
    req_valid_i = 1'b1; req_op_i = 2'd3; req_pc_i = 32'h8000_0100; cp0_index_i = 3'd3;
    cp0_random_i = 3'd0;
    tick(); req_valid_i = 1'b0; cp0_random_i = 3'd7; #1;
    checks++; if (ctl !== 10'b0001000100 || tlb_idx_o !== 3'd7)
      begin errors++; $display("FAIL wr_we: got ctl=%b idx=%0d exp 0001000100 idx=7", ctl, tlb_idx_o); end
    tick();
    checks++; if (ctl !== 10'b0000000110 || refetch_pc_o !== 32'h8000_0104)
      begin errors++; $display("FAIL wr_flush: got ctl=%b pc=%h exp 0000000110 pc=80000104", ctl, refetch_pc_o); end
    tick();
    checks++; if (ctl !== 10'b0000000001 || refetch_pc_o !== '0)
      begin errors++; $display("FAIL wr_done: got ctl=%b pc=%h exp 0000000001 pc=0", ctl, refetch_pc_o); end
    tick();
  endtask

  task automatic test_busy_wait();
    req_valid_i = 1'b1; req_op_i = 2'd2; req_pc_i = 32'hFFFF_FFFC; cp0_index_i = 3'd4;
    cp0_busy_i = 1'b1;
    tick(); req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) cp0_busy_i = 1'b0;
      #1;
      checks++; if (ctl !== 10'b0000000100)
        begin errors++; $display("FAIL busy_wait%0d: got ctl=%b exp 0000000100", i, ctl); end
      tick();
    end
    checks++; if (ctl !== 10'b0001000100 || tlb_idx_o !== 3'd4)
      begin errors++; $display("FAIL busy_issue: got ctl=%b idx=%0d exp 0001000100 idx=4", ctl, tlb_idx_o); end
    tick();
    checks++; if (ctl !== 10'b0000000110 || refetch_pc_o !== 32'h0000_0000)
      begin errors++; $display("FAIL wi_flush_wrap: got ctl=%b pc=%h exp 0000000110 pc=0", ctl, refetch_pc_o); end
    tick();
    checks++; if (ctl !== 10'b0000000001)
      begin errors++; $display("FAIL wi_done: got ctl=%b exp 0000000001", ctl); end
    tick();
  endtask

  task automatic test_kill_wait();
    req_valid_i = 1'b1; req_op_i = 2'd2; cp0_busy_i = 1'b1;
    tick(); req_valid_i = 1'b0; kill_i = 1'b1; #1;
    checks++; if (ctl !== 10'b0000000100)
      begin errors++; $display("FAIL kill_wait: got ctl=%b exp 0000000100", ctl); end
    tick(); kill_i = 1'b0; cp0_busy_i = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ctl !== 10'b1000000000)
        begin errors++; $display("FAIL kill_idle%0d: got ctl=%b exp 1000000000", i, ctl); end
      tick();
    end
  endtask

  task automatic test_tlbr_delay();
    req_valid_i = 1'b1; req_op_i = 2'd1; req_pc_i = 32'h0000_1000; cp0_index_i = 3'd3;
    tick(); req_valid_i = 1'b0; kill_i = 1'b1; #1;
    checks++; if (ctl !== 10'b0010000100 || tlb_idx_o !== 3'd3)
      begin errors++; $display("FAIL rd_issue: got ctl=%b idx=%0d exp 0010000100 idx=3", ctl, tlb_idx_o); end
    for (int i = 0; i < 4; i++) begin
      tick(); kill_i = (i == 0); #1;
      checks++; if (ctl !== 10'b0000000100)
        begin errors++; $display("FAIL rd_hold%0d: got ctl=%b exp 0000000100", i, ctl); end
    end
    tick(); tlb_resp_valid_i = 1'b1; #1;
    checks++; if (ctl !== 10'b0000010100)
      begin errors++; $display("FAIL rd_tlbr: got ctl=%b exp 0000010100", ctl); end
    tick(); tlb_resp_valid_i = 1'b0; #1;
    checks++; if (ctl !== 10'b0000000110 || refetch_pc_o !== 32'h0000_1004)
      begin errors++; $display("FAIL rd_flush: got ctl=%b pc=%h exp 0000000110 pc=00001004", ctl, refetch_pc_o); end
    tick();
    checks++; if (ctl !== 10'b0000000001)
      begin errors++; $display("FAIL rd_done: got ctl=%b exp 0000000001", ctl); end
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid_i = 1'b1; req_op_i = 2'd0; cp0_index_i = 3'd2;
    tick(); req_valid_i = 1'b0;
    tick();
    #2 rst_i = 1'b1;
    #1;
    checks++; if (ctl !== 10'b0)
      begin errors++; $display("FAIL rst_mid_outputs: got ctl=%b exp 0000000000", ctl); end
    tlb_resp_valid_i = 1'b1; tlb_hit_i = 1'b1;
    tick(); rst_i = 1'b0; #1;
    checks++; if (ctl !== 10'b1000000000)
      begin errors++; $display("FAIL rst_mid_idle: got ctl=%b exp 1000000000", ctl); end
    tlb_resp_valid_i = 1'b0; tlb_hit_i = 1'b0;
    req_valid_i = 1'b1; req_op_i = 2'd2; kill_i = 1'b1;
    tick(); req_valid_i = 1'b0; kill_i = 1'b0; #1;
    checks++; if (ctl !== 10'b1000000000)
      begin errors++; $display("FAIL kill_no_accept: got ctl=%b exp 1000000000", ctl); end
  endtask

  initial begin
    test_reset();
    test_tlbp_hit();
    test_tlbp_miss();
    test_tlbwr();
    test_busy_wait();
    test_kill_wait();
    test_tlbr_delay();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
